// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data loads/stores.
// Each access runs IDLE (grant + issue) -> WAIT (MEM_LAT cycles) -> RESP (valid pulse).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  // data port
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  // halt control
  input  logic              halt,
  output logic              halted,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata
);

  localparam int                CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(1);
  localparam logic [31:0]       NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             last_d_q,   last_d_d;
  logic             halted_q,   halted_d;
  logic             gnt_data_q, gnt_data_d;
  logic             gnt_wr_q,   gnt_wr_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q,  d_rdata_d;

  logic data_req;
  logic fetch_ok;
  logic grant_d;
  logic grant_f;
  logic issue_d;
  logic issue_f;

  // Arbitration: requests are only looked at in IDLE; last_d flips priority
  // so a stream of loads cannot starve fetch (and vice versa).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_d  = 1'b0;
    grant_f  = 1'b0;
    data_req = d_read | d_write;
    fetch_ok = if_req & ~halted_q;
    if (state_q == S_IDLE) begin
      if (data_req && fetch_ok) begin
        if (last_d_q) grant_f = 1'b1;
        else          grant_d = 1'b1;
      end else if (data_req) begin
        grant_d = 1'b1;
      end else if (fetch_ok) begin
        grant_f = 1'b1;
      end
    end
  end

  // The memory strobe must be quiet while reset is asserted, even though the
  // state register already sits in IDLE and requests may be high.
  assign issue_d = grant_d & rst_n;
  assign issue_f = grant_f & rst_n;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue_d) begin
      mem_en    = 1'b1;
      mem_we    = d_write;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (issue_f) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = 4'hF;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d_d   = last_d_q;
    gnt_data_d = gnt_data_q;
    gnt_wr_d   = gnt_wr_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    halted_d   = halted_q | halt;

    unique case (state_q)
      S_IDLE: begin
        if (grant_d || grant_f) begin
          state_d    = S_WAIT;
          cnt_d      = CNT_LOAD;
          gnt_data_d = grant_d;
          // read+write together is a store; the read half is dropped
          gnt_wr_d   = grant_d & d_write;
          last_d_d   = grant_d;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_LAST;
        if (cnt_q == CNT_LAST) begin
          state_d = S_RESP;
          if (!gnt_data_q)     if_rdata_d = mem_rdata;
          else if (!gnt_wr_q)  d_rdata_d  = mem_rdata;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_d_q   <= 1'b0;
      halted_q   <= 1'b0;
      gnt_data_q <= 1'b0;
      gnt_wr_q   <= 1'b0;
      if_rdata_q <= NOP_INSN;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_d_q   <= last_d_d;
      halted_q   <= halted_d;
      gnt_data_q <= gnt_data_d;
      gnt_wr_q   <= gnt_wr_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign halted   = halted_q;
  assign if_valid = (state_q == S_RESP) & ~gnt_data_q;
  assign d_valid  = (state_q == S_RESP) &  gnt_data_q;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = (d_read | d_write) & ~d_valid;

  a_valid_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(if_valid && d_valid));
  a_issue_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
    mem_en |-> (state_q == S_IDLE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiter instances (MEM_LAT=1 and MEM_LAT=3), each with a
// behavioural memory; expected responses are queued at stimulus time and popped on valid.
module tb_mem_port_arbiter;

  localparam logic [31:0] GARBAGE = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_valid  [2];
  logic        if_stall  [2];
  logic        d_read    [2];
  logic        d_write   [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [3:0]  d_be      [2];
  logic [31:0] d_rdata   [2];
  logic        d_valid   [2];
  logic        d_stall   [2];
  logic        halt      [2];
  logic        halted    [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_be    [2];
  logic [31:0] mem_rdata [2];

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] d_hold [2];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0050_0093;
      32'h40:  return 32'hDEAD_BEEF;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] pipe [L];

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(L)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_valid (if_valid[g]),
      .if_stall (if_stall[g]),
      .d_read   (d_read[g]),
      .d_write  (d_write[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_be     (d_be[g]),
      .d_rdata  (d_rdata[g]),
      .d_valid  (d_valid[g]),
      .d_stall  (d_stall[g]),
      .halt     (halt[g]),
      .halted   (halted[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_be   (mem_be[g]),
      .mem_rdata(mem_rdata[g])
    );

    // Read data for an issue in cycle 0 is presented throughout cycle L only.
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (mem_en[g] && !mem_we[g]) ? word(mem_addr[g]) : GARBAGE;
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_data, input logic [31:0] v);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = v;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the next valid pulse and compares it to the queue head.
  task automatic pop_resp(input int k, input int budget, output int cyc);
    exp_t e;
    bit   got;
    got = 1'b0;
    cyc = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (if_valid[k] || d_valid[k]) begin
        cyc = c;
        got = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL resp_timeout dut%0d: no valid pulse within %0d cycles", k, budget);
      return;
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL resp_unexpected dut%0d: valid pulse with empty scoreboard", k);
      return;
    end
    e = sb.pop_front();
    if (e.is_data) begin
      if (d_valid[k] !== 1'b1 || if_valid[k] !== 1'b0 || d_rdata[k] !== e.rdata) begin
        n_err++;
        $display("FAIL resp_data dut%0d: got d_valid=%b if_valid=%b d_rdata=%h, want data %h",
                 k, d_valid[k], if_valid[k], d_rdata[k], e.rdata);
      end
    end else begin
      if (if_valid[k] !== 1'b1 || d_valid[k] !== 1'b0 || if_rdata[k] !== e.rdata) begin
        n_err++;
        $display("FAIL resp_fetch dut%0d: got if_valid=%b d_valid=%b if_rdata=%h, want fetch %h",
                 k, if_valid[k], d_valid[k], if_rdata[k], e.rdata);
      end
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h10;
    d_read[0]  = 1'b1;
    d_addr[0]  = 32'h40;
    @(negedge clk);
    n_vec++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got en=%b we=%b addr=%h wdata=%h be=%h, want all 0",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]);
    end
    n_vec++;
    if (if_rdata[0] !== 32'h13 || d_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got if_rdata=%h d_rdata=%h, want 00000013/00000000",
               if_rdata[0], d_rdata[0]);
    end
    n_vec++;
    if ({if_valid[0], d_valid[0], if_stall[0], d_stall[0], halted[0], halted[1]} !== 6'b001100) begin
      n_err++;
      $display("FAIL reset_flags: got v/v/stall/stall/halted/halted=%b%b%b%b%b%b, want 001100",
               if_valid[0], d_valid[0], if_stall[0], d_stall[0], halted[0], halted[1]);
    end
    if_req[0] = 1'b0;
    d_read[0] = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    int cyc;
    step();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h10;
    push(1'b0, 32'h0050_0093);
    @(negedge clk);
    n_vec++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_be[0], if_stall[0]} !== {1'b1, 1'b0, 32'h10, 4'hF, 1'b1}) begin
      n_err++;
      $display("FAIL fetch_issue: got en=%b we=%b addr=%h be=%h stall=%b, want 1 0 10 f 1",
               mem_en[0], mem_we[0], mem_addr[0], mem_be[0], if_stall[0]);
    end
    step();
    @(negedge clk);
    n_vec++;
    if ({mem_en[0], if_valid[0], if_stall[0]} !== 3'b001) begin
      n_err++;
      $display("FAIL fetch_wait: got en=%b valid=%b stall=%b, want 0 0 1",
               mem_en[0], if_valid[0], if_stall[0]);
    end
    pop_resp(0, 6, cyc);
    n_vec++;
    if (cyc !== 0 || if_stall[0] !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_latency: got valid offset %0d stall=%b, want offset 0 stall 0",
               cyc, if_stall[0]);
    end
    step();
    if_req[0] = 1'b0;
  endtask

  task automatic test_contention();
    int cyc;
    step();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h10;
    d_read[0]  = 1'b1;
    d_addr[0]  = 32'h40;
    push(1'b1, 32'hDEAD_BEEF);
    push(1'b0, 32'h0050_0093);
    d_hold[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h40) begin
      n_err++;
      $display("FAIL contend_first: got en=%b addr=%h, want data grant at 40", mem_en[0], mem_addr[0]);
    end
    pop_resp(0, 6, cyc);
    n_vec++;
    if (cyc !== 1) begin
      n_err++;
      $display("FAIL contend_d_latency: got offset %0d, want 1", cyc);
    end
    step();
    d_read[0] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h10) begin
      n_err++;
      $display("FAIL contend_second: got en=%b addr=%h, want fetch grant at 10", mem_en[0], mem_addr[0]);
    end
    pop_resp(0, 6, cyc);
    step();
    if_req[0] = 1'b0;
  endtask

  task automatic test_fairness();
    int          cyc;
    logic [31:0] want_addr [3];
    want_addr[0] = 32'h80;
    want_addr[1] = 32'h10;
    want_addr[2] = 32'h84;
    step();
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h10;
    d_read[0]  = 1'b1;
    d_addr[0]  = 32'h80;
    push(1'b1, word(32'h80));
    push(1'b0, 32'h0050_0093);
    push(1'b1, word(32'h84));
    d_hold[0] = word(32'h84);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (mem_en[0] !== 1'b1 || mem_addr[0] !== want_addr[i]) begin
        n_err++;
        $display("FAIL fair_grant%0d: got en=%b addr=%h, want grant at %h",
                 i, mem_en[0], mem_addr[0], want_addr[i]);
      end
      pop_resp(0, 6, cyc);
      step();
      if (i == 0) d_addr[0] = 32'h84;
    end
    d_read[0] = 1'b0;
    if_req[0] = 1'b0;
  endtask

  task automatic test_store();
    int cyc;
    step();
    d_write[0] = 1'b1;
    d_addr[0]  = 32'h44;
    d_wdata[0] = 32'h1234_5678;
    d_be[0]    = 4'b0011;
    push(1'b1, d_hold[0]);
    @(negedge clk);
    n_vec++;
    if ({mem_en[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]} !==
        {1'b1, 1'b1, 4'b0011, 32'h44, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL store_issue: got en=%b we=%b be=%b addr=%h wdata=%h, want 1 1 0011 44 12345678",
               mem_en[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]);
    end
    pop_resp(0, 6, cyc);
    n_vec++;
    if (cyc !== 1) begin
      n_err++;
      $display("FAIL store_latency: got offset %0d, want 1", cyc);
    end
    step();
    // read and write together behave as a store
    d_read[0]  = 1'b1;
    d_addr[0]  = 32'h48;
    d_wdata[0] = 32'hCAFE_F00D;
    d_be[0]    = 4'hF;
    push(1'b1, d_hold[0]);
    @(negedge clk);
    n_vec++;
    if (mem_we[0] !== 1'b1 || mem_wdata[0] !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL rw_as_write: got we=%b wdata=%h, want 1 cafef00d", mem_we[0], mem_wdata[0]);
    end
    pop_resp(0, 6, cyc);
    step();
    d_read[0]  = 1'b0;
    d_write[0] = 1'b0;
    d_be[0]    = 4'h0;
  endtask

  task automatic test_back_to_back();
    int          cyc;
    logic [31:0] a;
    step();
    a          = 32'(($urandom_range(32, 255)) << 2);
    d_read[0]  = 1'b1;
    d_addr[0]  = a;
    push(1'b1, word(a));
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      pop_resp(0, 6, cyc);
      n_vec++;
      if (cyc !== 1) begin
        n_err++;
        $display("FAIL b2b_latency%0d: got offset %0d, want 1", i, cyc);
      end
      step();
      if (i == 5) begin
        d_read[0] = 1'b0;
        d_hold[0] = word(a);
      end else begin
        a         = 32'(($urandom_range(32, 255)) << 2);
        d_addr[0] = a;
        push(1'b1, word(a));
        @(negedge clk);
        n_vec++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== a) begin
          n_err++;
          $display("FAIL b2b_regrant%0d: got en=%b addr=%h, want 1 %h", i, mem_en[0], mem_addr[0], a);
        end
      end
    end
  endtask

  task automatic test_halt();
    int cyc;
    int bad_en;
    step();
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h10;
    push(1'b0, 32'h0050_0093);
    @(negedge clk);
    n_vec++;
    if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h10) begin
      n_err++;
      $display("FAIL halt_issue: got en=%b addr=%h, want 1 10", mem_en[1], mem_addr[1]);
    end
    step();
    halt[1] = 1'b1;
    step();
    halt[1] = 1'b0;
    @(negedge clk);
    n_vec++;
    if (halted[1] !== 1'b1) begin
      n_err++;
      $display("FAIL halt_sticky: got halted=%b, want 1", halted[1]);
    end
    pop_resp(1, 8, cyc);
    n_vec++;
    if (cyc !== 1) begin
      n_err++;
      $display("FAIL halt_fetch_done: got offset %0d (cycle %0d), want cycle 4", cyc, cyc + 3);
    end
    bad_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (mem_en[1] !== 1'b0 || if_stall[1] !== 1'b1) bad_en++;
    end
    n_vec++;
    if (bad_en !== 0) begin
      n_err++;
      $display("FAIL halt_blocks_fetch: got %0d cycles with mem_en or no stall, want 0", bad_en);
    end
    step();
    d_read[1] = 1'b1;
    d_addr[1] = 32'h40;
    push(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    n_vec++;
    if (mem_en[1] !== 1'b1 || mem_addr[1] !== 32'h40) begin
      n_err++;
      $display("FAIL halt_load_issue: got en=%b addr=%h, want 1 40", mem_en[1], mem_addr[1]);
    end
    pop_resp(1, 8, cyc);
    n_vec++;
    if (cyc !== 3 || halted[1] !== 1'b1) begin
      n_err++;
      $display("FAIL halt_load_done: got offset %0d halted=%b, want 3 1", cyc, halted[1]);
    end
    step();
    d_read[1] = 1'b0;
    if_req[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    step();
    d_read[0] = 1'b1;
    d_addr[0] = 32'h40;
    @(negedge clk);
    n_vec++;
    if (mem_en[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_issue: got en=%b, want 1", mem_en[0]);
    end
    step();
    rst_n      = 1'b0;
    d_read[0]  = 1'b0;
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h10;
    #1;
    n_vec++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0], if_valid[0], d_valid[0]} !== '0 ||
        if_rdata[0] !== 32'h13 || d_rdata[0] !== 32'h0 || if_stall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_outputs: got en=%b addr=%h v=%b%b if_rdata=%h d_rdata=%h stall=%b, want reset values",
               mem_en[0], mem_addr[0], if_valid[0], d_valid[0], if_rdata[0], d_rdata[0], if_stall[0]);
    end
    step();
    n_vec++;
    if (d_valid[0] !== 1'b0 || halted[1] !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_no_pulse: got d_valid=%b halted1=%b, want 0 0", d_valid[0], halted[1]);
    end
    rst_n = 1'b1;
    push(1'b0, 32'h0050_0093);
    @(negedge clk);
    n_vec++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h10) begin
      n_err++;
      $display("FAIL rstmid_regrant: got en=%b addr=%h, want 1 10", mem_en[0], mem_addr[0]);
    end
    pop_resp(0, 6, cyc);
    n_vec++;
    if (cyc !== 1 || d_rdata[0] !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_after: got offset %0d d_rdata=%h, want 1 00000000", cyc, d_rdata[0]);
    end
    step();
    if_req[0] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      if_req[k]  = 1'b0;
      if_addr[k] = '0;
      d_read[k]  = 1'b0;
      d_write[k] = 1'b0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
      d_be[k]    = '0;
      halt[k]    = 1'b0;
      d_hold[k]  = '0;
    end
    rst_n = 1'b0;
    test_reset();
    test_fetch();
    test_contention();
    test_fairness();
    test_store();
    test_back_to_back();
    test_halt();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d outstanding responses, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
